// File: rtl/render_queue_if.sv
// render_queue_if: Avalon-MM slave port plus the 48-bit render-queue pop port
// shared between the HPS bridge side and the VGA display engine.
interface render_queue_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [47:0] render_queue_dout;
  logic        render_queue_pop_front;
  logic        render_queue_empty;
  logic        render_queue_full;

  modport master (
    output chipselect, write, read, address, writedata, render_queue_pop_front,
    input  readdata, render_queue_dout, render_queue_empty, render_queue_full
  );

  modport slave (
    input  chipselect, write, read, address, writedata, render_queue_pop_front,
    output readdata, render_queue_dout, render_queue_empty, render_queue_full
  );
endinterface

// File: rtl/render_queue.sv
// render_queue: Avalon-MM slave that stages two 32-bit writes into 48-bit sprite
// render instructions and buffers them in a show-ahead FIFO for the display engine.
// Optional feature macro: RENDER_QUEUE_STATS_EN (high-water mark and dropped-push count at addr 3).
`ifndef VGA_DO_RENDER
`define VGA_DO_RENDER 8'h01
`endif

module render_queue #(
  parameter int DEPTH = 64
) (
  input logic           clk50,
  input logic           reset,
  render_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [47:0] IDLE_WORD = {`VGA_DO_RENDER, 40'h0};

  logic [47:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [31:0]   staging_lo;
  logic          overflow;
  logic [31:0]   readdata_q;

  logic          wr_access;
  logic          rd_access;
  logic          push_req;
  logic          flush_req;
  logic          status_read;
  logic          is_full;
  logic          is_empty;
  logic          do_push;
  logic          do_pop;
  logic          drop;
  logic [31:0]   status_word;
  logic [31:0]   stats_word;

  always_comb begin
    wr_access   = bus.chipselect & bus.write;
    rd_access   = bus.chipselect & bus.read;
    push_req    = wr_access && (bus.address == 2'd1);
    flush_req   = wr_access && (bus.address == 2'd3);
    status_read = rd_access && (bus.address == 2'd2);
    is_full     = (count == CW'(DEPTH));
    is_empty    = (count == '0);
    do_pop      = bus.render_queue_pop_front && !is_empty && !flush_req;
    // A same-cycle pop frees a slot, so a full queue still accepts the push.
    do_push     = push_req && (!is_full || bus.render_queue_pop_front);
    drop        = push_req && is_full && !bus.render_queue_pop_front;
    if (flush_req) begin
      count_next = '0;
    end else begin
      count_next = count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk50) begin
    if (reset || flush_req) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_next;
    end
  end

  always_ff @(posedge clk50) begin
    if (do_push && !reset) begin
      mem[wr_ptr] <= {bus.writedata[15:0], staging_lo};
    end
  end

  always_ff @(posedge clk50) begin
    if (reset || flush_req) begin
      staging_lo <= '0;
    end else if (wr_access && (bus.address == 2'd0)) begin
      staging_lo <= bus.writedata;
    end
  end

  // Sticky overflow: a drop on the same edge as a status read keeps it set.
  always_ff @(posedge clk50) begin
    if (reset || flush_req) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (status_read) begin
      overflow <= 1'b0;
    end
  end

`ifdef RENDER_QUEUE_STATS_EN
  logic [CW-1:0] hwm;
  logic [15:0]   dropped;

  always_ff @(posedge clk50) begin
    if (reset || flush_req) begin
      hwm     <= '0;
      dropped <= '0;
    end else begin
      if (count_next > hwm) begin
        hwm <= count_next;
      end
      if (drop && (dropped != 16'hFFFF)) begin
        dropped <= dropped + 16'd1;
      end
    end
  end

  always_comb begin
    stats_word = {dropped, 5'b0, 11'(hwm)};
  end
`else
  always_comb begin
    stats_word = '0;
  end
`endif

  always_comb begin
    status_word = {overflow, 14'b0, is_full, is_empty, 5'b0, 10'(count)};
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      readdata_q <= '0;
    end else if (rd_access) begin
      case (bus.address)
        2'd2:    readdata_q <= status_word;
        2'd3:    readdata_q <= stats_word;
        default: readdata_q <= '0;
      endcase
    end
  end

  assign bus.readdata           = readdata_q;
  assign bus.render_queue_dout  = is_empty ? IDLE_WORD : mem[rd_ptr];
  assign bus.render_queue_empty = is_empty;
  assign bus.render_queue_full  = is_full;

endmodule

// File: tb/tb_render_queue.sv
// tb_render_queue: randomized and directed checks of render_queue against a
// queue-based reference model of the register map and FIFO rules.
`ifndef VGA_DO_RENDER
`define VGA_DO_RENDER 8'h01
`endif

module tb_render_queue;
  localparam int DEPTH = 64;
  localparam logic [47:0] IDLE = {`VGA_DO_RENDER, 40'h0};

  logic clk50;
  logic reset;

  render_queue_if bus();

  render_queue #(.DEPTH(DEPTH)) dut (
    .clk50 (clk50),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  logic [47:0] model_q[$];
  bit          model_ovf;
  logic [31:0] model_staging;
  logic [31:0] exp_rd;
  int          model_hwm;
  int          model_dropped;
  int          checks;
  int          failures;

  task automatic clear_inputs();
    bus.chipselect             = 1'b0;
    bus.write                  = 1'b0;
    bus.read                   = 1'b0;
    bus.address                = 2'd0;
    bus.writedata              = 32'd0;
    bus.render_queue_pop_front = 1'b0;
  endtask

  task automatic model_reset();
    model_q.delete();
    model_ovf     = 1'b0;
    model_staging = '0;
    exp_rd        = '0;
    model_hwm     = 0;
    model_dropped = 0;
  endtask

  // One bus cycle: drive at negedge, advance the model at posedge, settle 1 time unit.
  task automatic cycle(input bit cs, input bit wr, input bit rd, input logic [1:0] a,
                       input logic [31:0] wd, input bit pop);
    int sz;
    @(negedge clk50);
    bus.chipselect             = cs;
    bus.write                  = wr;
    bus.read                   = rd;
    bus.address                = a;
    bus.writedata              = wd;
    bus.render_queue_pop_front = pop;
    @(posedge clk50);
    sz = model_q.size();
    if (cs && rd) begin
      if (a == 2'd2) begin
        exp_rd    = {model_ovf, 14'b0, sz == DEPTH, sz == 0, 5'b0, 10'(sz)};
        model_ovf = 1'b0;
      end else if (a == 2'd3) begin
`ifdef RENDER_QUEUE_STATS_EN
        exp_rd = {16'(model_dropped), 5'b0, 11'(model_hwm)};
`else
        exp_rd = '0;
`endif
      end else begin
        exp_rd = '0;
      end
    end
    if (cs && wr && a == 2'd3) begin
      model_q.delete();
      model_staging = '0;
      model_ovf     = 1'b0;
      model_hwm     = 0;
      model_dropped = 0;
    end else begin
      if (pop && sz > 0) void'(model_q.pop_front());
      if (cs && wr && a == 2'd1) begin
        if (model_q.size() < DEPTH) begin
          model_q.push_back({wd[15:0], model_staging});
        end else begin
          model_ovf = 1'b1;
          if (model_dropped < 65535) model_dropped++;
        end
      end
      if (cs && wr && a == 2'd0) model_staging = wd;
      if (model_q.size() > model_hwm) model_hwm = model_q.size();
    end
    #1;
    clear_inputs();
  endtask

  task automatic push_entry(input logic [47:0] e);
    cycle(1, 1, 0, 2'd0, e[31:0], 0);
    cycle(1, 1, 0, 2'd1, {16'h0, e[47:32]}, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk50);
    reset = 1'b1;
    clear_inputs();
    @(posedge clk50);
    @(posedge clk50);
    model_reset();
    @(negedge clk50);
    reset = 1'b0;
  endtask

  function automatic logic [47:0] model_dout();
    return (model_q.size() > 0) ? model_q[0] : IDLE;
  endfunction

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.readdata !== 32'h0) begin
      failures++; $display("FAIL reset_readdata: got %h expected %h", bus.readdata, 32'h0);
    end
    checks++;
    if (bus.render_queue_dout !== IDLE) begin
      failures++; $display("FAIL reset_dout: got %h expected %h", bus.render_queue_dout, IDLE);
    end
    checks++;
    if (bus.render_queue_empty !== 1'b1 || bus.render_queue_full !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got empty=%b full=%b expected empty=1 full=0",
                           bus.render_queue_empty, bus.render_queue_full);
    end
    cycle(1, 0, 1, 2'd2, 32'h0, 0);
    checks++;
    if (bus.readdata !== 32'h0000_8000) begin
      failures++; $display("FAIL reset_status: got %h expected %h", bus.readdata, 32'h0000_8000);
    end
  endtask

  task automatic test_single_push();
    cycle(1, 1, 0, 2'd0, 32'h4000_6401, 0);
    cycle(1, 1, 0, 2'd1, 32'h0000_0301, 0);
    checks++;
    if (bus.render_queue_dout !== 48'h0301_4000_6401) begin
      failures++; $display("FAIL single_dout: got %h expected %h", bus.render_queue_dout, 48'h0301_4000_6401);
    end
    checks++;
    if (bus.render_queue_empty !== 1'b0) begin
      failures++; $display("FAIL single_empty: got %b expected 0", bus.render_queue_empty);
    end
    cycle(1, 0, 1, 2'd2, 32'h0, 0);
    checks++;
    if (bus.readdata !== 32'h0000_0001) begin
      failures++; $display("FAIL single_status: got %h expected %h", bus.readdata, 32'h0000_0001);
    end
  endtask

  task automatic test_overflow();
    cycle(1, 1, 0, 2'd3, 32'h0, 0);
    for (int i = 0; i < DEPTH; i++) push_entry({$urandom, $urandom} & 48'hFFFF_FFFF_FFFF);
    checks++;
    if (bus.render_queue_full !== 1'b1 || bus.render_queue_dout !== model_dout()) begin
      failures++; $display("FAIL ovf_full: got full=%b dout=%h expected full=1 dout=%h",
                           bus.render_queue_full, bus.render_queue_dout, model_dout());
    end
    push_entry(48'hDEAD_BEEF_CAFE);
    cycle(1, 0, 1, 2'd2, 32'h0, 0);
    checks++;
    if (bus.readdata !== 32'h8001_0040) begin
      failures++; $display("FAIL ovf_status1: got %h expected %h", bus.readdata, 32'h8001_0040);
    end
    cycle(1, 0, 1, 2'd2, 32'h0, 0);
    checks++;
    if (bus.readdata !== 32'h0001_0040) begin
      failures++; $display("FAIL ovf_status2: got %h expected %h", bus.readdata, 32'h0001_0040);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 70; i++) begin
      cycle(0, 0, 0, 2'd0, 32'h0, 1);
      checks++;
      if (bus.render_queue_dout !== model_dout() ||
          bus.render_queue_empty !== (model_q.size() == 0)) begin
        failures++; $display("FAIL drain_dout step %0d: got %h empty=%b expected %h empty=%b", i,
                             bus.render_queue_dout, bus.render_queue_empty, model_dout(), model_q.size() == 0);
      end
    end
    checks++;
    if (bus.render_queue_dout !== IDLE) begin
      failures++; $display("FAIL drain_idle: got %h expected %h", bus.render_queue_dout, IDLE);
    end
    cycle(1, 0, 1, 2'd2, 32'h0, 0);
    checks++;
    if (bus.readdata !== 32'h0000_8000) begin
      failures++; $display("FAIL drain_status: got %h expected %h", bus.readdata, 32'h0000_8000);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] lo;
    logic [15:0] hi;
    lo = $urandom;
    hi = 16'($urandom);
    for (int i = 0; i < DEPTH; i++) push_entry({16'(i), 32'($urandom)});
    cycle(1, 1, 0, 2'd0, lo, 0);
    cycle(1, 1, 0, 2'd1, {16'h0, hi}, 1);
    cycle(1, 0, 1, 2'd2, 32'h0, 0);
    checks++;
    if (bus.readdata !== 32'h0001_0040) begin
      failures++; $display("FAIL fpp_status: got %h expected %h", bus.readdata, 32'h0001_0040);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        checks++;
        if (bus.render_queue_dout !== {hi, lo}) begin
          failures++; $display("FAIL fpp_last: got %h expected %h", bus.render_queue_dout, {hi, lo});
        end
      end
      cycle(0, 0, 0, 2'd0, 32'h0, 1);
      checks++;
      if (bus.render_queue_dout !== model_dout()) begin
        failures++; $display("FAIL fpp_dout step %0d: got %h expected %h", i, bus.render_queue_dout, model_dout());
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 10; i++) push_entry({16'hA5A5, 32'($urandom)});
    cycle(1, 0, 1, 2'd3, 32'h0, 0);
    checks++;
    if (bus.readdata !== exp_rd) begin
      failures++; $display("FAIL flush_stats_before: got %h expected %h", bus.readdata, exp_rd);
    end
    cycle(1, 1, 0, 2'd3, 32'h0, 1);
    checks++;
    if (bus.render_queue_empty !== 1'b1 || bus.render_queue_dout !== IDLE) begin
      failures++; $display("FAIL flush_empty: got empty=%b dout=%h expected empty=1 dout=%h",
                           bus.render_queue_empty, bus.render_queue_dout, IDLE);
    end
    cycle(1, 0, 1, 2'd2, 32'h0, 0);
    checks++;
    if (bus.readdata !== 32'h0000_8000) begin
      failures++; $display("FAIL flush_status: got %h expected %h", bus.readdata, 32'h0000_8000);
    end
    cycle(1, 0, 1, 2'd3, 32'h0, 0);
    checks++;
    if (bus.readdata !== 32'h0) begin
      failures++; $display("FAIL flush_stats: got %h expected %h", bus.readdata, 32'h0);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) push_entry({16'h1234, 32'($urandom)});
    apply_reset();
    checks++;
    if (bus.render_queue_empty !== 1'b1 || bus.render_queue_dout !== IDLE) begin
      failures++; $display("FAIL midreset_empty: got empty=%b dout=%h expected empty=1 dout=%h",
                           bus.render_queue_empty, bus.render_queue_dout, IDLE);
    end
    cycle(1, 1, 0, 2'd1, 32'hFFFF_ABCD, 0);
    checks++;
    if (bus.render_queue_dout !== 48'hABCD_0000_0000) begin
      failures++; $display("FAIL midreset_staging: got %h expected %h", bus.render_queue_dout, 48'hABCD_0000_0000);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      int          r;
      bit          pop;
      logic [31:0] wd;
      r   = $urandom_range(99);
      pop = ($urandom_range(99) < ((i % 400) < 250 ? 20 : 70));
      wd  = $urandom;
      if (r < 45)      cycle(1, 1, 0, 2'd1, wd, pop);
      else if (r < 60) cycle(1, 1, 0, 2'd0, wd, pop);
      else if (r < 74) cycle(1, 0, 1, 2'd2, 32'h0, pop);
      else if (r < 80) cycle(1, 0, 1, 2'd3, 32'h0, pop);
      else if (r < 84) cycle(1, 0, 1, 2'($urandom_range(1)), 32'h0, pop);
      else if (r < 88) cycle(0, 1, 1, 2'($urandom_range(3)), wd, pop);
      else if (r < 89) cycle(1, 1, 0, 2'd3, wd, pop);
      else if (r < 92) cycle(1, 1, 0, 2'd2, wd, pop);
      else             cycle(0, 0, 0, 2'd0, 32'h0, pop);
      checks++;
      if (bus.render_queue_dout !== model_dout()) begin
        failures++; $display("FAIL rand_dout cycle %0d: got %h expected %h", i, bus.render_queue_dout, model_dout());
      end
      checks++;
      if (bus.render_queue_empty !== (model_q.size() == 0) ||
          bus.render_queue_full !== (model_q.size() == DEPTH)) begin
        failures++; $display("FAIL rand_flags cycle %0d: got empty=%b full=%b expected size %0d", i,
                             bus.render_queue_empty, bus.render_queue_full, model_q.size());
      end
      checks++;
      if (bus.readdata !== exp_rd) begin
        failures++; $display("FAIL rand_readdata cycle %0d: got %h expected %h", i, bus.readdata, exp_rd);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_single_push();
    test_overflow();
    test_drain();
    test_full_push_pop();
    test_flush();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
